// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-wide memory: sub-word loads are extracted and extended, sub-word stores use read-modify-write.
// Latency: error 1, load 2, word store 2, sub-word store 3 cycles; one request at a time. Optional counters under LSU_STATS_EN.
module lsu_mem_master #(
  parameter int MEM_BYTES = 800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [31:0] mem_write_data,
`ifdef LSU_STATS_EN
  output logic [15:0] stat_loads,
  output logic [15:0] stat_stores,
  output logic [15:0] stat_errors,
`endif
  input  logic [31:0] mem_read_data
);

  localparam logic [31:0] LIMIT = 32'(MEM_BYTES - 4);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WRITE, S_RMW_RD, S_RMW_WR, S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] base_q, wdata_q, merge_q, merge_d;
  logic [1:0]  lane_q, size_q;
  logic        signed_q, write_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] req_base;
  logic [1:0]  req_lane;
  logic        req_bad;
  logic        accept;

  assign req_base = {req_addr[31:2], 2'b00};
  assign req_lane = req_addr[1:0];
  assign req_bad  = (req_size == 2'b11)
                 || (req_size == 2'b10 && req_lane != 2'b00)
                 || (req_size == 2'b01 && req_lane == 2'b11)
                 || (req_base > LIMIT);
  assign accept   = (state_q == S_IDLE) && req_valid;

  logic [4:0]  shamt;
  logic [31:0] shifted, load_ext, lane_mask, lane_ins, merged;

  assign shamt   = {lane_q, 3'b000};
  assign shifted = mem_read_data >> shamt;

  always_comb begin
    load_ext = mem_read_data;
    case (size_q)
      2'b00:   load_ext = signed_q ? {{24{shifted[7]}}, shifted[7:0]}
                                   : {24'h0, shifted[7:0]};
      2'b01:   load_ext = signed_q ? {{16{shifted[15]}}, shifted[15:0]}
                                   : {16'h0, shifted[15:0]};
      default: load_ext = mem_read_data;
    endcase
  end

  // Only the addressed lane(s) of the previously read word are replaced.
  assign lane_mask = (size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
  assign lane_ins  = (size_q == 2'b00) ? {24'h0, wdata_q[7:0]} : {16'h0, wdata_q[15:0]};
  assign merged    = (merge_q & ~(lane_mask << shamt)) | (lane_ins << shamt);

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    merge_d = merge_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            state_d = S_RESP;
            rdata_d = 32'h0;
            err_d   = 1'b1;
          end else if (!req_write) begin
            state_d = S_READ;
          end else if (req_size == 2'b10) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_READ: begin
        state_d = S_RESP;
        rdata_d = load_ext;
        err_d   = 1'b0;
      end
      S_WRITE: begin
        state_d = S_RESP;
        rdata_d = 32'h0;
        err_d   = 1'b0;
      end
      S_RMW_RD: begin
        state_d = S_RMW_WR;
        merge_d = mem_read_data;
      end
      S_RMW_WR: begin
        state_d = S_RESP;
        rdata_d = 32'h0;
        err_d   = 1'b0;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      base_q   <= 32'h0;
      wdata_q  <= 32'h0;
      merge_q  <= 32'h0;
      lane_q   <= 2'b00;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      merge_q <= merge_d;
      if (accept) begin
        base_q   <= req_base;
        wdata_q  <= req_wdata;
        lane_q   <= req_lane;
        size_q   <= req_size;
        signed_q <= req_signed;
        write_q  <= req_write;
      end
    end
  end

  // Memory port is decoded from state and captured registers only.
  always_comb begin
    mem_address    = 32'h0;
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    mem_write_data = 32'h0;
    case (state_q)
      S_READ, S_RMW_RD: begin
        mem_address = base_q;
        mem_read_en = 1'b1;
      end
      S_WRITE: begin
        mem_address    = base_q;
        mem_write_en   = 1'b1;
        mem_write_data = wdata_q;
      end
      S_RMW_WR: begin
        mem_address    = base_q;
        mem_write_en   = 1'b1;
        mem_write_data = merged;
      end
      default: ;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

`ifdef LSU_STATS_EN
  logic [15:0] loads_q, stores_q, errors_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loads_q  <= 16'h0;
      stores_q <= 16'h0;
      errors_q <= 16'h0;
    end else if (state_q == S_RESP) begin
      if (err_q) begin
        if (errors_q != 16'hFFFF) errors_q <= errors_q + 16'd1;
      end else if (write_q) begin
        if (stores_q != 16'hFFFF) stores_q <= stores_q + 16'd1;
      end else begin
        if (loads_q != 16'hFFFF) loads_q <= loads_q + 16'd1;
      end
    end
  end

  assign stat_loads  = loads_q;
  assign stat_stores = stores_q;
  assign stat_errors = errors_q;
`endif

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a posedge-write / negedge-read byte memory model.
module tb_lsu_mem_master;

  localparam int MEM_BYTES = 800;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
`ifdef LSU_STATS_EN
  logic [15:0] stat_loads, stat_stores, stat_errors;
`endif

  lsu_mem_master #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_address(mem_address), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
`ifdef LSU_STATS_EN
    .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errors(stat_errors),
`endif
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:MEM_BYTES-1];
  logic saw_en, saw_both, saw_resp;

  always @(posedge clk) begin
    if (mem_write_en && mem_address <= 32'(MEM_BYTES - 4)) begin
      mem[mem_address]      <= mem_write_data[7:0];
      mem[mem_address + 1]  <= mem_write_data[15:8];
      mem[mem_address + 2]  <= mem_write_data[23:16];
      mem[mem_address + 3]  <= mem_write_data[31:24];
    end
  end

  always @(negedge clk) begin
    if (mem_read_en && mem_address <= 32'(MEM_BYTES - 4))
      mem_read_data <= {mem[mem_address + 3], mem[mem_address + 2],
                        mem[mem_address + 1], mem[mem_address]};
    else
      mem_read_data <= 32'hzzzz_zzzz;
    if (mem_read_en || mem_write_en) saw_en = 1'b1;
    if (mem_read_en && mem_write_en) saw_both = 1'b1;
    if (resp_valid) saw_resp = 1'b1;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd,
                        output logic er, output logic en);
    @(negedge clk);
    saw_en    = 1'b0;
    req_valid = 1'b1;
    req_write = w;
    req_size  = sz;
    req_signed = sg;
    req_addr  = a;
    req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 99;
    rd  = 32'hDEAD_DEAD;
    er  = 1'bx;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = i;
        rd  = resp_rdata;
        er  = resp_err;
        break;
      end
    end
    en = saw_en;
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_er;
    int          exp_lat;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_er, input int exp_lat);
    vec_t v;
    v.w = w; v.sz = sz; v.sg = sg; v.a = a; v.wd = wd;
    v.exp_rd = exp_rd; v.exp_er = exp_er; v.exp_lat = exp_lat;
    tbl.push_back(v);
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er, en;

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
    saw_en = 1'b0; saw_both = 1'b0; saw_resp = 1'b0;

    #12;
    check("rst_ready", {31'b0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_resp_err", {31'b0, resp_err}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_en", {30'b0, mem_read_en, mem_write_en}, 32'h0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_mem_wdata", mem_write_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, lat, rd, er, en);
    check("wst_lat", lat, 2);
    check("wst_rdata", rd, 32'h0);
    check("wst_err", {31'b0, er}, 32'h0);
    @(negedge clk);
    check("byte10", {24'b0, mem[16]}, 32'h44);
    check("byte11", {24'b0, mem[17]}, 32'h33);
    check("byte12", {24'b0, mem[18]}, 32'h22);
    check("byte13", {24'b0, mem[19]}, 32'h11);

    //  w    size   sg    addr    wdata          exp_rdata      err  lat
    add(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h1122_3344, 1'b0, 2);
    add(1'b0, 2'b00, 1'b0, 32'h13, 32'h0,         32'h0000_0011, 1'b0, 2);
    add(1'b0, 2'b00, 1'b1, 32'h13, 32'h0,         32'h0000_0011, 1'b0, 2);
    add(1'b1, 2'b10, 1'b0, 32'h20, 32'h8000_1234, 32'h0,         1'b0, 2);
    add(1'b0, 2'b01, 1'b1, 32'h22, 32'h0,         32'hFFFF_8000, 1'b0, 2);
    add(1'b0, 2'b01, 1'b0, 32'h22, 32'h0,         32'h0000_8000, 1'b0, 2);
    add(1'b0, 2'b01, 1'b1, 32'h20, 32'h0,         32'h0000_1234, 1'b0, 2);
    add(1'b0, 2'b00, 1'b1, 32'h23, 32'h0,         32'hFFFF_FF80, 1'b0, 2);
    add(1'b0, 2'b00, 1'b1, 32'h21, 32'h0,         32'h0000_0012, 1'b0, 2);
    add(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FFAB, 32'h0,         1'b0, 3);
    add(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h1122_AB44, 1'b0, 2);
    add(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234_BEEF, 32'h0,         1'b0, 3);
    add(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'hBEEF_AB44, 1'b0, 2);
    add(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_5566, 32'h0,         1'b0, 3);
    add(1'b1, 2'b00, 1'b0, 32'h10, 32'h0000_0077, 32'h0,         1'b0, 3);
    add(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'hBE55_6677, 1'b0, 2);
    add(1'b0, 2'b10, 1'b0, 32'h12, 32'h0,         32'h0,         1'b1, 1);
    add(1'b0, 2'b01, 1'b0, 32'h13, 32'h0,         32'h0,         1'b1, 1);
    add(1'b0, 2'b11, 1'b0, 32'h10, 32'h0,         32'h0,         1'b1, 1);
    add(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFF_FFFF, 32'h0,         1'b1, 1);
    add(1'b1, 2'b01, 1'b0, 32'h13, 32'hFFFF_FFFF, 32'h0,         1'b1, 1);
    add(1'b0, 2'b10, 1'b0, 32'd798, 32'h0,        32'h0,         1'b1, 1);
    add(1'b0, 2'b10, 1'b0, 32'd800, 32'h0,        32'h0,         1'b1, 1);
    add(1'b1, 2'b10, 1'b0, 32'd800, 32'h1,        32'h0,         1'b1, 1);
    add(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'hBE55_6677, 1'b0, 2);
    add(1'b1, 2'b10, 1'b0, 32'd796, 32'hCAFE_F00D, 32'h0,        1'b0, 2);
    add(1'b0, 2'b00, 1'b1, 32'd799, 32'h0,        32'hFFFF_FFCA, 1'b0, 2);
    add(1'b0, 2'b10, 1'b0, 32'd796, 32'h0,        32'hCAFE_F00D, 1'b0, 2);

    foreach (tbl[i]) begin
      do_req(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, lat, rd, er, en);
      check($sformatf("v%0d_lat", i), lat, tbl[i].exp_lat);
      check($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, tbl[i].exp_er});
      check($sformatf("v%0d_mem_en", i), {31'b0, en}, {31'b0, ~tbl[i].exp_er});
    end
    check("no_dual_enable", {31'b0, saw_both}, 32'h0);

    // Back-to-back with req_valid held high across both requests.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    check("b2b_ready0", {31'b0, req_ready}, 32'h1);
    @(posedge clk);
    #1 req_addr = 32'h20;
    @(negedge clk);
    check("b2b_ready_read", {31'b0, req_ready}, 32'h0);
    check("b2b_valid_read", {31'b0, resp_valid}, 32'h0);
    @(negedge clk);
    check("b2b_ready_resp", {31'b0, req_ready}, 32'h0);
    check("b2b_valid_resp", {31'b0, resp_valid}, 32'h1);
    check("b2b_rdata1", resp_rdata, 32'hBE55_6677);
    @(negedge clk);
    check("b2b_ready_idle", {31'b0, req_ready}, 32'h1);
    check("b2b_valid_idle", {31'b0, resp_valid}, 32'h0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("b2b_ready_read2", {31'b0, req_ready}, 32'h0);
    check("b2b_rd_en2", {31'b0, mem_read_en}, 32'h1);
    @(negedge clk);
    check("b2b_valid2", {31'b0, resp_valid}, 32'h1);
    check("b2b_rdata2", resp_rdata, 32'h8000_1234);
    check("b2b_hold_err", {31'b0, resp_err}, 32'h0);

    // Reset in the middle of a read-modify-write.
    do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'h0102_0304, lat, rd, er, en);
    check("rmw_pre_lat", lat, 2);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h31; req_wdata = 32'h0000_00FF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rmw_rd_en", {31'b0, mem_read_en}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_rd_en", {31'b0, mem_read_en}, 32'h0);
    check("rst_mid_wr_en", {31'b0, mem_write_en}, 32'h0);
    check("rst_mid_ready", {31'b0, req_ready}, 32'h1);
    saw_resp = 1'b0;
    saw_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_no_resp", {31'b0, saw_resp}, 32'h0);
    check("rst_no_mem_en", {31'b0, saw_en}, 32'h0);
    check("rst_ready_after", {31'b0, req_ready}, 32'h1);
    check("rst_word_mem", {mem[51], mem[50], mem[49], mem[48]}, 32'h0102_0304);
    do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, lat, rd, er, en);
    check("rst_word_load", rd, 32'h0102_0304);
    check("rst_word_lat", lat, 2);

`ifdef LSU_STATS_EN
    @(negedge clk);
    check("stat_loads", {16'b0, stat_loads}, 32'd1);
    check("stat_stores", {16'b0, stat_stores}, 32'd0);
    check("stat_errors", {16'b0, stat_errors}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
